// File: rtl/forwarding_unit.sv
// rtl/forwarding_unit.sv - EX operand forwarding selects, load-use stall and saturating stall counter
module forwarding_unit #(
    parameter int NB_REG = 5,
    parameter int NB_CNT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_flush,
    input  logic              i_id_valid,
    input  logic [NB_REG-1:0] i_id_rs1,
    input  logic [NB_REG-1:0] i_id_rs2,
    input  logic              i_id_uses_rs1,
    input  logic              i_id_uses_rs2,
    input  logic [NB_REG-1:0] i_id_rd,
    input  logic              i_id_reg_write,
    input  logic              i_id_mem_read,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b,
    output logic              o_stall,
    output logic [NB_CNT-1:0] o_stall_cnt
);

    localparam logic [NB_CNT-1:0] CNT_ONE = 1;

    // Only EX and MEM are tracked: WB results reach EX through the register
    // file write-through, so a WB slot would never influence any output.
    logic              ex_valid;
    logic [NB_REG-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              mem_valid;
    logic [NB_REG-1:0] mem_rd;
    logic              mem_reg_write;

    logic ex_live;
    logic mem_live;
    logic ex_wr_rs1;
    logic ex_wr_rs2;
    logic mem_wr_rs1;
    logic mem_wr_rs2;
    logic hazard;
    logic enter_ex;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    assign ex_live    = ex_valid & ex_reg_write & (ex_rd != '0);
    assign mem_live   = mem_valid & mem_reg_write & (mem_rd != '0);
    assign ex_wr_rs1  = ex_live & (ex_rd == i_id_rs1);
    assign ex_wr_rs2  = ex_live & (ex_rd == i_id_rs2);
    assign mem_wr_rs1 = mem_live & (mem_rd == i_id_rs1);
    assign mem_wr_rs2 = mem_live & (mem_rd == i_id_rs2);

    assign hazard   = i_id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                      ((i_id_uses_rs1 & (i_id_rs1 == ex_rd)) |
                       (i_id_uses_rs2 & (i_id_rs2 == ex_rd)));
    assign o_stall  = hazard & ~i_flush;
    assign enter_ex = i_id_valid & ~o_stall & ~i_flush;

    // A load in EX never yields 01 here: a matching reader is stalled instead.
    always_comb begin
        sel_a = 2'b00;
        sel_b = 2'b00;
        if (enter_ex && i_id_uses_rs1) begin
            if (ex_wr_rs1)       sel_a = 2'b01;
            else if (mem_wr_rs1) sel_a = 2'b10;
        end
        if (enter_ex && i_id_uses_rs2) begin
            if (ex_wr_rs2)       sel_b = 2'b01;
            else if (mem_wr_rs2) sel_b = 2'b10;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_valid      <= 1'b0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            mem_valid     <= 1'b0;
            mem_rd        <= '0;
            mem_reg_write <= 1'b0;
            o_fwd_a       <= 2'b00;
            o_fwd_b       <= 2'b00;
            o_stall_cnt   <= '0;
        end else if (i_en) begin
            mem_valid     <= ex_valid;
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            ex_valid      <= enter_ex;
            ex_rd         <= enter_ex ? i_id_rd : '0;
            ex_reg_write  <= enter_ex & i_id_reg_write;
            ex_mem_read   <= enter_ex & i_id_mem_read;
            o_fwd_a       <= sel_a;
            o_fwd_b       <= sel_b;
            if (o_stall && (o_stall_cnt != '1))
                o_stall_cnt <= o_stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_forwarding_unit.sv
// tb/tb_forwarding_unit.sv - randomized and directed checks of forwarding_unit against a queue model
module tb_forwarding_unit;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_en = 1'b1;
    logic       i_flush = 1'b0;
    logic       i_id_valid = 1'b0;
    logic [4:0] i_id_rs1 = '0;
    logic [4:0] i_id_rs2 = '0;
    logic       i_id_uses_rs1 = 1'b0;
    logic       i_id_uses_rs2 = 1'b0;
    logic [4:0] i_id_rd = '0;
    logic       i_id_reg_write = 1'b0;
    logic       i_id_mem_read = 1'b0;

    logic [1:0]  fwd_a, fwd_b, fwd_a2, fwd_b2;
    logic        stall, stall2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    always #5 i_clk = ~i_clk;

    forwarding_unit #(.NB_REG(5), .NB_CNT(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_flush(i_flush),
        .i_id_valid(i_id_valid), .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
        .i_id_uses_rs1(i_id_uses_rs1), .i_id_uses_rs2(i_id_uses_rs2),
        .i_id_rd(i_id_rd), .i_id_reg_write(i_id_reg_write), .i_id_mem_read(i_id_mem_read),
        .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_stall(stall), .o_stall_cnt(cnt)
    );

    forwarding_unit #(.NB_REG(5), .NB_CNT(2)) dut_sat (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_flush(i_flush),
        .i_id_valid(i_id_valid), .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
        .i_id_uses_rs1(i_id_uses_rs1), .i_id_uses_rs2(i_id_uses_rs2),
        .i_id_rd(i_id_rd), .i_id_reg_write(i_id_reg_write), .i_id_mem_read(i_id_mem_read),
        .o_fwd_a(fwd_a2), .o_fwd_b(fwd_b2), .o_stall(stall2), .o_stall_cnt(cnt2)
    );

    // Behavioural model: in-flight instructions, newest first (EX, then MEM).
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       rw;
        bit       mr;
    } inst_t;

    inst_t pipe[$];
    int    m_fa = 0, m_fb = 0, m_cnt = 0, m_cnt2 = 0;

    function automatic bit writes(inst_t s, bit [4:0] r);
        return s.v && s.rw && s.rd != 0 && s.rd == r;
    endfunction

    // Forward from the newest in-flight writer: distance 1 -> EX/MEM, 2 -> MEM/WB.
    function automatic int source_of(bit [4:0] r);
        for (int i = 0; i < pipe.size(); i++)
            if (writes(pipe[i], r)) return i + 1;
        return 0;
    endfunction

    function automatic bit model_stall();
        bit hit;
        if (pipe.size() == 0 || !i_id_valid || i_flush) return 1'b0;
        if (!(pipe[0].v && pipe[0].mr && pipe[0].rd != 0)) return 1'b0;
        hit = (i_id_uses_rs1 && i_id_rs1 == pipe[0].rd) ||
              (i_id_uses_rs2 && i_id_rs2 == pipe[0].rd);
        return hit;
    endfunction

    always @(posedge i_clk) begin
        inst_t nw;
        bit st, enter;
        if (i_rst) begin
            pipe.delete();
            m_fa = 0; m_fb = 0; m_cnt = 0; m_cnt2 = 0;
        end else if (i_en) begin
            st = model_stall();
            enter = i_id_valid && !st && !i_flush;
            m_fa = (enter && i_id_uses_rs1) ? source_of(i_id_rs1) : 0;
            m_fb = (enter && i_id_uses_rs2) ? source_of(i_id_rs2) : 0;
            if (st) begin
                m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
                m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
            end
            nw.v = enter; nw.rd = enter ? i_id_rd : 5'd0;
            nw.rw = enter && i_id_reg_write; nw.mr = enter && i_id_mem_read;
            pipe.push_front(nw);
            while (pipe.size() > 2) void'(pipe.pop_back());
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        if (checking) begin
            chk("model fwd_a", 16'(fwd_a), 16'(m_fa));
            chk("model fwd_b", 16'(fwd_b), 16'(m_fb));
            chk("model stall", 16'(stall), 16'(model_stall()));
            chk("model cnt", cnt, 16'(m_cnt));
            chk("model fwd_a sat", 16'(fwd_a2), 16'(m_fa));
            chk("model stall sat", 16'(stall2), 16'(model_stall()));
            chk("model cnt sat", 16'(cnt2), 16'(m_cnt2));
        end
    end

    task automatic drive(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                         input int rd, input bit rw, input bit mr, input bit fl);
        @(posedge i_clk); #2;
        i_id_valid = v; i_id_rs1 = 5'(rs1); i_id_rs2 = 5'(rs2);
        i_id_uses_rs1 = u1; i_id_uses_rs2 = u2; i_id_rd = 5'(rd);
        i_id_reg_write = rw; i_id_mem_read = mr; i_flush = fl;
    endtask

    task automatic alu_w(input int rd);            drive(1, 0, 0, 0, 0, rd, 1, 0, 0); endtask
    task automatic alu_r(input int rs1, input int rs2, input int rd);
        drive(1, rs1, rs2, 1, 1, rd, 1, 0, 0);
    endtask
    task automatic load(input int rd);             drive(1, 1, 0, 1, 0, rd, 1, 1, 0); endtask
    task automatic nop();                          drive(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic settle();                       @(negedge i_clk); #1; endtask

    initial begin
        repeat (2) @(posedge i_clk);
        #2 i_rst = 1'b0;
        checking = 1'b1;

        // Reset with loaded slots
        alu_w(5); alu_w(6); load(7);
        #1 i_rst = 1'b1;
        @(posedge i_clk); #2 i_rst = 1'b0; nop();
        settle();
        chk("reset fwd_a", 16'(fwd_a), 16'h0);
        chk("reset fwd_b", 16'(fwd_b), 16'h0);
        chk("reset stall", 16'(stall), 16'h0);
        chk("reset cnt", cnt, 16'h0);

        // EX->EX and MEM->EX
        alu_w(5); alu_r(5, 7, 6); nop(); settle();
        chk("ex fwd_a", 16'(fwd_a), 16'h1);
        chk("ex fwd_b", 16'(fwd_b), 16'h0);
        nop(); alu_w(5); alu_w(9); alu_r(5, 0, 6); nop(); settle();
        chk("mem fwd_a", 16'(fwd_a), 16'h2);

        // Priority and x0
        nop(); alu_w(5); alu_w(5); alu_r(5, 0, 6); nop(); settle();
        chk("priority fwd_a", 16'(fwd_a), 16'h1);
        nop(); alu_w(0); alu_w(0); alu_r(0, 0, 6); nop(); settle();
        chk("x0 fwd_a", 16'(fwd_a), 16'h0);
        chk("x0 fwd_b", 16'(fwd_b), 16'h0);

        // Load-use: one stall cycle, then both operands from MEM/WB
        nop(); nop(); load(3); alu_r(3, 3, 4); settle();
        chk("lu stall", 16'(stall), 16'h1);
        @(posedge i_clk); #2; settle();
        chk("lu stall drop", 16'(stall), 16'h0);
        chk("lu cnt", cnt, 16'h1);
        nop(); settle();
        chk("lu fwd_a", 16'(fwd_a), 16'h2);
        chk("lu fwd_b", 16'(fwd_b), 16'h2);

        // Flush wins over stall
        nop(); load(3); drive(1, 3, 3, 1, 1, 4, 1, 0, 1); settle();
        chk("flush stall", 16'(stall), 16'h0);
        nop(); settle();
        chk("flush cnt", cnt, 16'h1);

        // Enable low for three cycles between producer and consumer
        nop(); alu_w(5); alu_r(5, 7, 6);
        i_en = 1'b0;
        repeat (3) @(posedge i_clk);
        #2 i_en = 1'b1;
        nop(); settle();
        chk("en fwd_a", 16'(fwd_a), 16'h1);

        // Saturation of the 2-bit counter
        for (int k = 0; k < 5; k++) begin
            nop(); load(3); alu_r(3, 0, 4);
            @(posedge i_clk); #2;
        end
        nop(); settle();
        chk("sat cnt16", cnt, 16'h6);
        chk("sat cnt2", 16'(cnt2), 16'h3);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit v, mr;
            v  = ($urandom_range(0, 7) != 0);
            mr = ($urandom_range(0, 2) == 0);
            drive(v, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                  $urandom_range(0, 3), mr || ($urandom_range(0, 3) != 0), mr,
                  $urandom_range(0, 9) == 0);
            i_en  = ($urandom_range(0, 7) != 0);
            i_rst = ($urandom_range(0, 199) == 0);
        end
        @(posedge i_clk); #2 i_rst = 1'b0; i_en = 1'b1;
        repeat (3) @(posedge i_clk);
        settle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
